// File: rtl/divu_hilo.sv
// divu_hilo: multi-cycle unsigned divider with MIPS-style HI/LO result registers.
// A DIVU takes WIDTH restoring steps; HI/LO only change at the commit edge.
module divu_hilo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   output logic [WIDTH-1:0] Output,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [5:0] FN_DIVU = 6'd27;
   localparam logic [5:0] FN_MFHI = 6'd16;
   localparam logic [5:0] FN_MFLO = 6'd18;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;

   // One restoring step: shift {rem,quo} left, trial-subtract, keep or restore.
   // The shifted remainder needs one extra bit since rem can be up to divisor-1.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      quo_nx  = {quo[WIDTH-2:0], ~diff[WIDTH]};
      rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   end

   // Control FSM, iteration datapath and HI/LO commit with registered flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         divisor  <= '0;
         rem      <= '0;
         quo      <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (Signal == FN_DIVU) begin
                  divisor <= dataB;
                  quo     <= dataA;
                  rem     <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            RUN: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + CW'(1);
               if (cnt == LAST_STEP) begin
                  hi       <= rem_nx;
                  lo       <= quo_nx;
                  div_zero <= (divisor == '0);
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Combinational HI/LO read port.
   always_comb begin
      Output = '0;
      if (Signal == FN_MFHI)      Output = hi;
      else if (Signal == FN_MFLO) Output = lo;
   end

endmodule

// File: tb/tb_divu_hilo.sv
// Self-checking bench for divu_hilo: directed cases plus random divisions
// compared against plain '/' and '%' arithmetic.
module tb_divu_hilo;

   localparam int unsigned W = 32;

   logic          clk;
   logic          reset;
   logic [W-1:0]  dataA;
   logic [W-1:0]  dataB;
   logic [5:0]    Signal;
   logic [W-1:0]  Output;
   logic          busy;
   logic          done;
   logic          div_zero;

   int unsigned   checks;
   int unsigned   errors;

   // reference state
   logic [W-1:0]  m_hi;
   logic [W-1:0]  m_lo;
   logic          m_dz;

   divu_hilo #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .dataA    (dataA),
      .dataB    (dataB),
      .Signal   (Signal),
      .Output   (Output),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic rd(input logic [5:0] fn, input string tag, input logic [W-1:0] exp);
      Signal = fn;
      #1;
      chk(tag, Output, exp);
      Signal = 6'd0;
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) begin
         m_hi = a;
         m_lo = '1;
         m_dz = 1'b1;
      end else begin
         m_hi = a % b;
         m_lo = a / b;
         m_dz = 1'b0;
      end
   endtask

   // Issue DIVU a/b, follow it to the DONE cycle checking busy/done timing,
   // then check HI/LO/div_zero. Returns with the DUT in its DONE cycle.
   task automatic divu(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
      Signal = 6'd27;
      dataA  = a;
      dataB  = b;
      step();
      Signal = 6'd0;
      dataA  = $urandom;
      dataB  = $urandom;
      for (int k = 0; k < W; k++) begin
         chk("busy_run", {31'd0, busy}, 32'd1);
         chk("done_run", {31'd0, done}, 32'd0);
         if (inject && k == 10) begin
            rd(6'd18, "mflo_during_run", m_lo);
            rd(6'd16, "mfhi_during_run", m_hi);
            Signal = 6'd27;
            dataA  = 32'd50;
            dataB  = 32'd5;
         end
         step();
         Signal = 6'd0;
      end
      model(a, b);
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_done", {31'd0, busy}, 32'd0);
      rd(6'd16, "mfhi", m_hi);
      rd(6'd18, "mflo", m_lo);
      chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
   endtask

   // One idle cycle after a DONE cycle: done must have dropped.
   task automatic settle();
      step();
      chk("done_drop", {31'd0, done}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [5:0]   fn;
      checks = 0;
      errors = 0;
      m_hi = '0;
      m_lo = '0;
      m_dz = 1'b0;
      Signal = 6'd0;
      dataA  = '0;
      dataB  = '0;
      reset  = 1'b0;

      // reset state
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dz", {31'd0, div_zero}, 32'd0);
      rd(6'd16, "rst_hi", 32'd0);
      rd(6'd18, "rst_lo", 32'd0);
      rd(6'd27, "out_other_fn", 32'd0);
      step();
      step();
      reset = 1'b1;

      // 100/7, first DIVU right after reset release
      divu(32'd100, 32'd7, 1'b0);
      chk("d100_7_hi", m_hi, 32'd2);
      chk("d100_7_lo", m_lo, 32'd14);
      settle();

      // large dividend, divisor 1; then dividend < divisor
      divu(32'hFFFF_FFFF, 32'd1, 1'b0);
      settle();
      divu(32'd3, 32'd10, 1'b0);
      settle();

      // divide by zero then recovery
      divu(32'd5, 32'd0, 1'b0);
      settle();
      divu(32'd9, 32'd3, 1'b0);
      settle();

      // DIVU during RUN ignored; MFHI/MFLO during RUN give prior result
      divu(32'd100, 32'd7, 1'b1);
      settle();

      // reset mid-run aborts with no commit
      Signal = 6'd27;
      dataA  = 32'd1000;
      dataB  = 32'd3;
      step();
      Signal = 6'd0;
      for (int k = 0; k < 12; k++) step();
      reset = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      rd(6'd16, "abort_hi", 32'd0);
      rd(6'd18, "abort_lo", 32'd0);
      m_hi = '0;
      m_lo = '0;
      m_dz = 1'b0;
      step();
      reset = 1'b1;
      for (int k = 0; k < W + 4; k++) begin
         step();
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      divu(32'd1000, 32'd3, 1'b0);
      settle();

      // back-to-back: second DIVU issued in the DONE cycle
      divu(32'd100, 32'd7, 1'b0);
      divu(32'h8000_0000, 32'h10, 1'b0);
      settle();

      // random divisions with back-to-back issue and idle no-op functions
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = $urandom_range(1, 15);
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         divu(a, b, 1'b0);
         if ($urandom_range(0, 1) == 0) begin
            settle();
            fn = 6'($urandom_range(0, 63));
            if (fn == 6'd27) fn = 6'd26;
            Signal = fn;
            step();
            Signal = 6'd0;
            chk("noop_busy", {31'd0, busy}, 32'd0);
            rd(6'd16, "noop_hi", m_hi);
            rd(6'd18, "noop_lo", m_lo);
         end
      end
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
